div_issue_ctrl: RTL

- EX-stage controller that sits directly upstream of the multi-cycle iterative divider.
- Accepts DIV/DIVU from the EX stage, latches the operands and drives the divider's start/signed/operand/cancel inputs.
- Holds the pipeline via a stall request until the divider finishes, then writes remainder/quotient to HI/LO.
- Handles divide-by-zero, pipeline flush and a watchdog timeout.

---
 rtl/div_issue_ctrl_if.sv | 31 +++
 rtl/div_issue_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl_if.sv
// Handshake bundle between the EX-stage divide controller
// and the multi-cycle iterative divider.
interface div_issue_ctrl_if;
    logic        div_start_o;
    logic        div_signed_o;
    logic [31:0] div_dividend_o;
    logic [31:0] div_divider_o;
    logic        div_cancel_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;

    modport master (
        output div_start_o,
        output div_signed_o,
        output div_dividend_o,
        output div_divider_o,
        output div_cancel_o,
        input  div_result_i,
        input  div_ready_i
    );

    modport slave (
        input  div_start_o,
        input  div_signed_o,
        input  div_dividend_o,
        input  div_divider_o,
        input  div_cancel_o,
        output div_result_i,
        output div_ready_i
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// EX-stage issue controller for the iterative divider:
// operand latch, stall, HI/LO write, flush and watchdog.
module div_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 48
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              div_valid_i,
    input  logic              div_signed_i,
    input  logic [31:0]       rs_data_i,
    input  logic [31:0]       rt_data_i,
    input  logic              flush_i,
    input  logic              ex_hold_i,
    div_issue_ctrl_if.master  dv,
    output logic              stall_req_o,
    output logic              hilo_we_o,
    output logic [31:0]       hi_o,
    output logic [31:0]       lo_o,
    output logic              div_zero_o,
    output logic              div_err_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [31:0]   a_q, b_q;
    logic          sgn_q;
    logic [CW-1:0] cnt_q;
    logic          busy;
    logic          issue;
    logic          wr;
    logic          tmo;
    logic          cancel;
    logic          stall;
    logic          zero;

    assign busy = (state == BUSY);

    always_comb begin
        state_n = state;
        issue   = 1'b0;
        wr      = 1'b0;
        tmo     = 1'b0;
        cancel  = 1'b0;
        stall   = 1'b0;
        zero    = 1'b0;
        unique case (state)
            IDLE: begin
                if (div_valid_i && !flush_i) begin
                    if (rt_data_i != 32'd0) begin
                        issue   = 1'b1;
                        stall   = 1'b1;
                        state_n = BUSY;
                    end else begin
                        zero = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (flush_i) begin
                    cancel  = 1'b1;
                    state_n = IDLE;
                end else begin
                    stall = 1'b1;
                    if (dv.div_ready_i) begin
                        wr      = 1'b1;
                        state_n = DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        cancel  = 1'b1;
                        tmo     = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                // Holding here keeps a stalled EX from re-issuing the same divide
                if (!(ex_hold_i && !flush_i)) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            sgn_q     <= 1'b0;
            cnt_q     <= '0;
            hilo_we_o <= 1'b0;
            div_err_o <= 1'b0;
            hi_o      <= 32'd0;
            lo_o      <= 32'd0;
        end else begin
            state     <= state_n;
            hilo_we_o <= wr;
            div_err_o <= tmo;
            if (issue) begin
                a_q   <= rs_data_i;
                b_q   <= rt_data_i;
                sgn_q <= div_signed_i;
                cnt_q <= '0;
            end else if (busy) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (wr) begin
                hi_o <= dv.div_result_i[63:32];
                lo_o <= dv.div_result_i[31:0];
            end
        end
    end

    // Operands stay frozen for the whole divide; the divider reads them late
    assign dv.div_start_o    = busy;
    assign dv.div_signed_o   = busy & sgn_q;
    assign dv.div_dividend_o = busy ? a_q : 32'd0;
    assign dv.div_divider_o  = busy ? b_q : 32'd0;
    assign dv.div_cancel_o   = cancel;
    assign stall_req_o       = stall;
    assign div_zero_o        = zero;

endmodule
